// File: rtl/multiplier_n_bits_seq.sv
// Sequential N x N shift-add multiplier.
// A and B are buffered from a shared data bus. The block has a start/busy/done
// handshake, a signed/unsigned mode, and an accumulate mode with a sticky
// overflow flag.
module multiplier_n_bits_seq #(
    parameter int N = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_data_in,
    input  logic           i_load_a,
    input  logic           i_load_b,
    input  logic           i_start,
    input  logic           i_signed_mode,
    input  logic           i_acc_mode,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_result,
    output logic           o_overflow
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [N-1:0]    r_a, r_b;
    logic [N-1:0]    r_mcand;     // multiplicand magnitude for this op
    logic [2*N-1:0]  r_pp;        // {partial sum, remaining multiplier bits}
    logic [CW-1:0]   r_cnt;
    logic            r_sign;      // product must be negated at the end
    logic            r_acc;
    logic            r_smode;

    logic [N-1:0]    w_a_neg, w_b_neg, w_a_mag, w_b_mag;
    logic [N:0]      w_add;
    logic [2*N-1:0]  w_pp_next, w_pp_neg, w_prod, w_base;
    logic [2*N:0]    w_sum;
    logic            w_ovf;

    // Operand magnitudes. Negating -2^(N-1) gives 2^(N-1), which is the
    // correct unsigned magnitude.
    assign w_a_neg = -r_a;
    assign w_b_neg = -r_b;
    assign w_a_mag = (i_signed_mode && r_a[N-1]) ? w_a_neg : r_a;
    assign w_b_mag = (i_signed_mode && r_b[N-1]) ? w_b_neg : r_b;

    // One shift-add step. The carry out of the upper half is shifted back in.
    assign w_add     = {1'b0, r_pp[2*N-1:N]} + {1'b0, (r_pp[0] ? r_mcand : {N{1'b0}})};
    assign w_pp_next = {w_add, r_pp[N-1:1]};

    // Final sign fix-up and accumulate. These are only consumed on the last RUN cycle.
    assign w_pp_neg = -w_pp_next;
    assign w_prod   = r_sign ? w_pp_neg : w_pp_next;
    assign w_base   = r_acc ? o_result : {(2*N){1'b0}};
    assign w_sum    = {1'b0, w_base} + {1'b0, w_prod};
    assign w_ovf    = r_acc & (r_smode
                    ? ((w_base[2*N-1] == w_prod[2*N-1]) && (w_sum[2*N-1] != w_base[2*N-1]))
                    : w_sum[2*N]);

    // Control FSM: operand buffers, datapath registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_mcand    <= '0;
            r_pp       <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_acc      <= 1'b0;
            r_smode    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_result   <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (r_state != S_RUN) begin
                if (i_load_a) r_a <= i_data_in;
                if (i_load_b) r_b <= i_data_in;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        // r_a/r_b here are the values from before any same-edge load.
                        r_mcand <= w_a_mag;
                        r_pp    <= {{N{1'b0}}, w_b_mag};
                        r_sign  <= i_signed_mode & (r_a[N-1] ^ r_b[N-1]);
                        r_acc   <= i_acc_mode;
                        r_smode <= i_signed_mode;
                        r_cnt   <= CW'(N);
                        if (!i_acc_mode) o_overflow <= 1'b0;
                        o_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_pp  <= w_pp_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        o_result <= w_sum[2*N-1:0];
                        if (w_ovf) o_overflow <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_n_bits_seq.sv
// Directed bench for multiplier_n_bits_seq with N=8.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_multiplier_n_bits_seq;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   data_in = '0;
    logic           load_a = 1'b0, load_b = 1'b0, start = 1'b0;
    logic           signed_mode = 1'b0, acc_mode = 1'b0;
    logic           busy, done, overflow;
    logic [2*N-1:0] result;

    int n_pass = 0;
    int n_total = 0;
    int lat, ndone, both, busy_mid;

    multiplier_n_bits_seq #(.N(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in),
        .i_load_a(load_a), .i_load_b(load_b), .i_start(start),
        .i_signed_mode(signed_mode), .i_acc_mode(acc_mode),
        .o_busy(busy), .o_done(done), .o_result(result), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic load_ab(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk); data_in = a; load_a = 1'b1;
        @(negedge clk); load_a = 1'b0; data_in = b; load_b = 1'b1;
        @(negedge clk); load_b = 1'b0;
    endtask

    // Pulse start, then watch a fixed 14-cycle window. Edge 0 is the start edge.
    // lat is the first edge whose sampled done is 1, which is one edge after
    // done is registered. If poke_k > 0, load_a=0x12 and start are driven
    // during the cycle after edge poke_k.
    task automatic run_op(input logic acc, input logic sm, input int poke_k);
        @(negedge clk); start = 1'b1; acc_mode = acc; signed_mode = sm;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        lat = 0; ndone = 0; both = 0; busy_mid = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            load_a = 1'b0; start = 1'b0;
            if (k == poke_k) begin data_in = 8'h12; load_a = 1'b1; start = 1'b1; end
            if (busy && done) both++;
            if (k == N - 1) busy_mid = busy;
            if (done) begin
                ndone++;
                if (lat == 0) lat = k + 1;
            end
        end
        load_a = 1'b0; start = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk); rst_n = 1'b1;

        // 1: unsigned 0xFF*0xFF, latency and handshake
        load_ab(8'hFF, 8'hFF);
        run_op(1'b0, 1'b0, 0);
        chk("t1_latency", lat, 9);
        chk("t1_result", result, 16'hFE01);
        chk("t1_busy_mid", busy_mid, 1);
        chk("t1_one_done", ndone, 1);
        chk("t1_busy_done_excl", both, 0);

        // 2: signed
        load_ab(8'h80, 8'h80);
        run_op(1'b0, 1'b1, 0);
        chk("t2_m128sq", result, 16'h4000);
        load_ab(8'hFF, 8'h01);
        run_op(1'b0, 1'b1, 0);
        chk("t2_neg1", result, 16'hFFFF);
        load_ab(8'h00, 8'h80);
        run_op(1'b0, 1'b1, 0);
        chk("t2_zero_neg", result, 16'h0000);

        // 3: accumulate from reset, with overflow stickiness and clear
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        load_ab(8'hFF, 8'hFF);
        run_op(1'b1, 1'b0, 0);
        chk("t3_acc1", result, 16'hFE01);
        chk("t3_ovf1", overflow, 0);
        run_op(1'b1, 1'b0, 0);
        chk("t3_acc2", result, 16'hFC02);
        chk("t3_ovf2", overflow, 1);
        run_op(1'b1, 1'b0, 0);
        chk("t3_acc3", result, 16'hFA03);
        chk("t3_ovf3", overflow, 1);
        run_op(1'b0, 1'b0, 0);
        chk("t3_clear_res", result, 16'hFE01);
        chk("t3_clear_ovf", overflow, 0);

        // 4: load and start during RUN are ignored
        load_ab(8'd3, 8'd5);
        run_op(1'b0, 1'b0, 3);
        chk("t4_result", result, 16'd15);
        chk("t4_one_done", ndone, 1);
        run_op(1'b0, 1'b0, 0);
        chk("t4_a_kept", result, 16'd15);

        // 5: a load on the start edge affects only the next op
        @(negedge clk); data_in = 8'd7; load_a = 1'b1; start = 1'b1; acc_mode = 1'b0; signed_mode = 1'b0;
        @(negedge clk); load_a = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);
        chk("t5_old_a", result, 16'd15);
        run_op(1'b0, 1'b0, 0);
        chk("t5_new_a", result, 16'd35);

        // 6: reset during RUN aborts immediately
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_result", result, 0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t6_no_done", ndone, 0);
        load_ab(8'd6, 8'd9);
        run_op(1'b0, 1'b0, 0);
        chk("t6_next_op", result, 16'd54);
        chk("t6_next_lat", lat, 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
